// File: rtl/ocx_tlx_tx_bdi_pkg.sv
// Shared constants and types for the TLX transmit BDI packer.
// Optional build macro: OCX_TLX_TX_BDI_INJECT_EN (adds cfg_bdi_inject to the top).
package ocx_tlx_tx_bdi_pkg;

    // A control/bookend flit carries at most eight data-flit BDI bits.
    localparam int BDI_MAX_RUN = 8;

    // Virtual-channel encoding used on data_pull_vc.
    localparam logic VC0_RESP = 1'b0;
    localparam logic VC1_CMD  = 1'b1;

    // Run-accumulator state; encodings fixed for compatibility with older logic.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FULL  = 2'd2
    } run_state_t;

    // Bit positions inside bdi_err.
    localparam int BDI_ERR_QOVF = 0;
    localparam int BDI_ERR_UNDF = 1;
    localparam int BDI_ERR_ROVF = 2;

endpackage

// File: rtl/ocx_tlx_bdi_bitfifo.sv
// Parameterised 1-bit queue holding one BDI bit per queued data beat.
// A push while full is dropped and flagged; a pop while empty is flagged
// and leaves the pointers alone. There is no push-to-pop bypass.
module ocx_tlx_bdi_bitfifo
    import ocx_tlx_tx_bdi_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic tlx_clk,
    input  logic reset_n,
    input  logic push,
    input  logic push_bit,
    input  logic pop,
    output logic pop_bit,
    output logic empty,
    output logic overflow,
    output logic underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0]      mem;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    // count never exceeds DEPTH, so its top bit alone marks a full queue
    assign full      = count[ADDR_WIDTH];
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign overflow  = push & full;
    assign underflow = pop & empty;
    assign pop_bit   = mem[rd_ptr];

    // Pointer and occupancy update; simultaneous push and pop leaves count unchanged
    always_ff @(posedge tlx_clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Bit storage; contents after reset are irrelevant because count gates reads
    always_ff @(posedge tlx_clk) begin
        if (do_push) mem[wr_ptr] <= push_bit;
    end

endmodule

// File: rtl/ocx_tlx_tx_bdi_pack.sv
// Transmit-side BDI packer: queues one BDI bit per AFU data beat on VC0/VC1,
// dequeues in framer pull order and packs each data run into the 8-bit BDI
// field of the next control/bookend flit.
// Optional build macro: OCX_TLX_TX_BDI_INJECT_EN adds cfg_bdi_inject, which
// forces every bit entering the s1 stage to 1.
//
// run_state | meaning
// IDLE      | no beats accumulated in the current run
// ACCUM     | 1..7 beats accumulated
// FULL      | 8 beats accumulated; further beats are dropped and flagged
module ocx_tlx_tx_bdi_pack
    import ocx_tlx_tx_bdi_pkg::*;
#(
    parameter int resp_addr_width = 6,
    parameter int cmd_addr_width  = 6
) (
    input  logic       tlx_clk,
    input  logic       reset_n,
    input  logic       afu_tlx_rdata_valid,
    input  logic       afu_tlx_rdata_bdi,
    input  logic       afu_tlx_cdata_valid,
    input  logic       afu_tlx_cdata_bdi,
    input  logic       data_pull_v,
    input  logic       data_pull_vc,
    input  logic       ctl_flit_send,
`ifdef OCX_TLX_TX_BDI_INJECT_EN
    input  logic       cfg_bdi_inject,
`endif
    output logic [7:0] tx_bdi,
    output logic [3:0] tx_run_length,
    output logic       tx_bdi_valid,
    output logic       resp_bdi_empty,
    output logic       cmd_bdi_empty,
    output logic [2:0] bdi_err
);

    logic       resp_pop, cmd_pop;
    logic       resp_bit, cmd_bit;
    logic       resp_ovf, cmd_ovf;
    logic       resp_udf, cmd_udf;
    logic       sel_empty, sel_bit, pull_bit, s1_in;
    logic       s1_v, s1_bit;
    logic [7:0] acc, acc_m;
    logic [3:0] acc_cnt, cnt_m;
    logic       run_ovf;
    logic [2:0] err_set;
    run_state_t run_state, run_state_nxt;

    assign resp_pop = data_pull_v & (data_pull_vc == VC0_RESP);
    assign cmd_pop  = data_pull_v & (data_pull_vc == VC1_CMD);

    ocx_tlx_bdi_bitfifo #(.ADDR_WIDTH(resp_addr_width)) u_resp_fifo (
        .tlx_clk   (tlx_clk),
        .reset_n   (reset_n),
        .push      (afu_tlx_rdata_valid),
        .push_bit  (afu_tlx_rdata_bdi),
        .pop       (resp_pop),
        .pop_bit   (resp_bit),
        .empty     (resp_bdi_empty),
        .overflow  (resp_ovf),
        .underflow (resp_udf)
    );

    ocx_tlx_bdi_bitfifo #(.ADDR_WIDTH(cmd_addr_width)) u_cmd_fifo (
        .tlx_clk   (tlx_clk),
        .reset_n   (reset_n),
        .push      (afu_tlx_cdata_valid),
        .push_bit  (afu_tlx_cdata_bdi),
        .pop       (cmd_pop),
        .pop_bit   (cmd_bit),
        .empty     (cmd_bdi_empty),
        .overflow  (cmd_ovf),
        .underflow (cmd_udf)
    );

    // An underflowing pull has no real beat behind it, so it is reported as bad
    assign sel_empty = (data_pull_vc == VC1_CMD) ? cmd_bdi_empty : resp_bdi_empty;
    assign sel_bit   = (data_pull_vc == VC1_CMD) ? cmd_bit : resp_bit;
    assign pull_bit  = sel_empty ? 1'b1 : sel_bit;

`ifdef OCX_TLX_TX_BDI_INJECT_EN
    assign s1_in = pull_bit | cfg_bdi_inject;
`else
    assign s1_in = pull_bit;
`endif

    // s1 stage: the pulled bit lands here one cycle after the pull
    always_ff @(posedge tlx_clk) begin
        if (!reset_n) begin
            s1_v   <= 1'b0;
            s1_bit <= 1'b0;
        end else begin
            s1_v   <= data_pull_v;
            s1_bit <= s1_in;
        end
    end

    // Accumulator with the current s1 beat merged in; also the value captured on close
    always_comb begin
        acc_m   = acc;
        cnt_m   = acc_cnt;
        run_ovf = 1'b0;
        if (s1_v) begin
            if (run_state == FULL) begin
                run_ovf = 1'b1;
            end else begin
                acc_m[acc_cnt[2:0]] = s1_bit;
                cnt_m               = acc_cnt + 4'd1;
            end
        end
    end

    // Run-state transitions; closing a run always returns to IDLE
    always_comb begin
        run_state_nxt = run_state;
        case (run_state)
            IDLE:    if (s1_v) run_state_nxt = ACCUM;
            ACCUM:   if (s1_v && acc_cnt == 4'(BDI_MAX_RUN - 1)) run_state_nxt = FULL;
            FULL:    run_state_nxt = FULL;
            default: run_state_nxt = IDLE;
        endcase
        if (ctl_flit_send) run_state_nxt = IDLE;
    end

    // Accumulator and run-state registers; cleared when the run is closed
    always_ff @(posedge tlx_clk) begin
        if (!reset_n) begin
            acc       <= '0;
            acc_cnt   <= '0;
            run_state <= IDLE;
        end else begin
            run_state <= run_state_nxt;
            if (ctl_flit_send) begin
                acc     <= '0;
                acc_cnt <= '0;
            end else begin
                acc     <= acc_m;
                acc_cnt <= cnt_m;
            end
        end
    end

    // Close output: capture the merged run and strobe valid for one cycle
    always_ff @(posedge tlx_clk) begin
        if (!reset_n) begin
            tx_bdi        <= '0;
            tx_run_length <= '0;
            tx_bdi_valid  <= 1'b0;
        end else begin
            tx_bdi_valid <= ctl_flit_send;
            if (ctl_flit_send) begin
                tx_bdi        <= acc_m;
                tx_run_length <= cnt_m;
            end
        end
    end

    always_comb begin
        err_set               = '0;
        err_set[BDI_ERR_QOVF] = resp_ovf | cmd_ovf;
        err_set[BDI_ERR_UNDF] = resp_udf | cmd_udf;
        err_set[BDI_ERR_ROVF] = run_ovf;
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge tlx_clk) begin
        if (!reset_n) bdi_err <= '0;
        else          bdi_err <= bdi_err | err_set;
    end

endmodule

// File: tb/tb_ocx_tlx_tx_bdi_pack.sv
// Self-checking bench for ocx_tlx_tx_bdi_pack: a queue-based reference model
// compared every cycle, plus hand-computed literal expectations.
// Honours OCX_TLX_TX_BDI_INJECT_EN when defined.
module tb_ocx_tlx_tx_bdi_pack;

    localparam int RDEPTH = 64;
    localparam int CDEPTH = 64;

    logic       tlx_clk = 1'b0;
    logic       reset_n;
    logic       afu_tlx_rdata_valid, afu_tlx_rdata_bdi;
    logic       afu_tlx_cdata_valid, afu_tlx_cdata_bdi;
    logic       data_pull_v, data_pull_vc, ctl_flit_send;
`ifdef OCX_TLX_TX_BDI_INJECT_EN
    logic       cfg_bdi_inject;
`endif
    logic [7:0] tx_bdi;
    logic [3:0] tx_run_length;
    logic       tx_bdi_valid, resp_bdi_empty, cmd_bdi_empty;
    logic [2:0] bdi_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    always #5 tlx_clk = ~tlx_clk;

    ocx_tlx_tx_bdi_pack #(.resp_addr_width(6), .cmd_addr_width(6)) dut (
        .tlx_clk             (tlx_clk),
        .reset_n             (reset_n),
        .afu_tlx_rdata_valid (afu_tlx_rdata_valid),
        .afu_tlx_rdata_bdi   (afu_tlx_rdata_bdi),
        .afu_tlx_cdata_valid (afu_tlx_cdata_valid),
        .afu_tlx_cdata_bdi   (afu_tlx_cdata_bdi),
        .data_pull_v         (data_pull_v),
        .data_pull_vc        (data_pull_vc),
        .ctl_flit_send       (ctl_flit_send),
`ifdef OCX_TLX_TX_BDI_INJECT_EN
        .cfg_bdi_inject      (cfg_bdi_inject),
`endif
        .tx_bdi              (tx_bdi),
        .tx_run_length       (tx_run_length),
        .tx_bdi_valid        (tx_bdi_valid),
        .resp_bdi_empty      (resp_bdi_empty),
        .cmd_bdi_empty       (cmd_bdi_empty),
        .bdi_err             (bdi_err)
    );

    // ---------------- reference model ----------------
    bit         q0[$];
    bit         q1[$];
    bit         run[$];
    bit         m_s1v, m_s1b;
    logic [7:0] m_bdi;
    logic [3:0] m_len;
    logic       m_valid;
    logic [2:0] m_err;
    bit         f0, f1, nb;

    always @(posedge tlx_clk) begin
        if (!reset_n) begin
            q0.delete(); q1.delete(); run.delete();
            m_s1v = 0; m_s1b = 0;
            m_bdi = '0; m_len = '0; m_valid = 0; m_err = '0;
        end else begin
            // beat sitting in s1 this cycle joins the current run
            if (m_s1v) begin
                if (run.size() == 8) m_err[2] = 1'b1;
                else                 run.push_back(m_s1b);
            end
            if (ctl_flit_send) begin
                m_bdi = '0;
                foreach (run[i]) m_bdi[i] = run[i];
                m_len   = 4'(run.size());
                m_valid = 1'b1;
                run.delete();
            end else begin
                m_valid = 1'b0;
            end
            // full status before this cycle's pull: no room is freed for a same-cycle push
            f0 = (q0.size() == RDEPTH);
            f1 = (q1.size() == CDEPTH);
            nb = 1'b0;
            if (data_pull_v) begin
                if (data_pull_vc == 1'b0) begin
                    if (q0.size() == 0) begin nb = 1'b1; m_err[1] = 1'b1; end
                    else nb = q0.pop_front();
                end else begin
                    if (q1.size() == 0) begin nb = 1'b1; m_err[1] = 1'b1; end
                    else nb = q1.pop_front();
                end
`ifdef OCX_TLX_TX_BDI_INJECT_EN
                if (cfg_bdi_inject) nb = 1'b1;
`endif
            end
            if (afu_tlx_rdata_valid) begin
                if (f0) m_err[0] = 1'b1;
                else    q0.push_back(afu_tlx_rdata_bdi);
            end
            if (afu_tlx_cdata_valid) begin
                if (f1) m_err[0] = 1'b1;
                else    q1.push_back(afu_tlx_cdata_bdi);
            end
            m_s1v = data_pull_v;
            m_s1b = nb;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model, away from the active edge
    always @(negedge tlx_clk) begin
        if (chk_en) begin
            check("cyc_valid",      32'(tx_bdi_valid),   32'(m_valid));
            check("cyc_bdi",        32'(tx_bdi),         32'(m_bdi));
            check("cyc_len",        32'(tx_run_length),  32'(m_len));
            check("cyc_err",        32'(bdi_err),        32'(m_err));
            check("cyc_resp_empty", 32'(resp_bdi_empty), 32'(q0.size() == 0));
            check("cyc_cmd_empty",  32'(cmd_bdi_empty),  32'(q1.size() == 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge tlx_clk);
        #1;
        afu_tlx_rdata_valid = 0; afu_tlx_rdata_bdi = 0;
        afu_tlx_cdata_valid = 0; afu_tlx_cdata_bdi = 0;
        data_pull_v = 0; data_pull_vc = 0; ctl_flit_send = 0;
    endtask

    task automatic push_r(input bit b);
        afu_tlx_rdata_valid = 1; afu_tlx_rdata_bdi = b; step();
    endtask

    task automatic pull(input bit vc);
        data_pull_v = 1; data_pull_vc = vc; step();
    endtask

    task automatic close_run();
        ctl_flit_send = 1; step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit vcs[5];
        reset_n = 0;
        afu_tlx_rdata_valid = 0; afu_tlx_rdata_bdi = 0;
        afu_tlx_cdata_valid = 0; afu_tlx_cdata_bdi = 0;
        data_pull_v = 0; data_pull_vc = 0; ctl_flit_send = 0;
`ifdef OCX_TLX_TX_BDI_INJECT_EN
        cfg_bdi_inject = 0;
`endif
        step();
        chk_en = 1;
        step();
        check("rst_valid", 32'(tx_bdi_valid), 0);
        check("rst_bdi",   32'(tx_bdi), 0);
        check("rst_len",   32'(tx_run_length), 0);
        check("rst_err",   32'(bdi_err), 0);
        check("rst_empty", 32'({resp_bdi_empty, cmd_bdi_empty}), 32'b11);
        reset_n = 1;
        step();

        // interleaved run: VC0 queue 1,0,1 and VC1 queue 0,1
        afu_tlx_rdata_valid = 1; afu_tlx_rdata_bdi = 1; afu_tlx_cdata_valid = 1; afu_tlx_cdata_bdi = 0; step();
        afu_tlx_rdata_valid = 1; afu_tlx_rdata_bdi = 0; afu_tlx_cdata_valid = 1; afu_tlx_cdata_bdi = 1; step();
        push_r(1);
        vcs = '{0, 1, 0, 1, 0};
        foreach (vcs[i]) pull(vcs[i]);
        close_run();
        // pulled bits VC0=1, VC1=0, VC0=0, VC1=1, VC0=1 -> bits 0..4 = 1,0,0,1,1
        check("interleave_bdi",   32'(tx_bdi), 32'h19);
        check("interleave_len",   32'(tx_run_length), 5);
        check("interleave_valid", 32'(tx_bdi_valid), 1);
        step();
        check("strobe_one_cycle", 32'(tx_bdi_valid), 0);
        check("bdi_hold",         32'(tx_bdi), 32'h19);

        // close while s1 holds the third beat: it belongs to the closing run
        push_r(0); push_r(0); push_r(1);
        pull(0); pull(0); pull(0);
        close_run();
        check("merge_bdi", 32'(tx_bdi), 32'h04);
        check("merge_len", 32'(tx_run_length), 3);
        close_run();
        check("empty_run_bdi",   32'(tx_bdi), 0);
        check("empty_run_len",   32'(tx_run_length), 0);
        check("empty_run_valid", 32'(tx_bdi_valid), 1);

        // nine all-ones VC1 beats into one run
        repeat (9) begin afu_tlx_cdata_valid = 1; afu_tlx_cdata_bdi = 1; step(); end
        repeat (9) pull(1);
        step(); step();
        check("run_ovf_err", 32'(bdi_err), 32'b100);
        close_run();
        check("run_ovf_bdi", 32'(tx_bdi), 32'hFF);
        check("run_ovf_len", 32'(tx_run_length), 8);

        // underflow pull on empty VC0
        pull(0);
        close_run();
        check("udf_bdi",   32'(tx_bdi), 32'h01);
        check("udf_len",   32'(tx_run_length), 1);
        check("udf_err",   32'(bdi_err), 32'b110);
        check("udf_empty", 32'(resp_bdi_empty), 1);

        // 65 pushes into a 64-deep VC0 queue; bit i = (i % 3 == 0)
        for (int i = 0; i < RDEPTH + 1; i++) push_r(i % 3 == 0);
        check("qovf_err",   32'(bdi_err), 32'b111);
        check("qovf_empty", 32'(resp_bdi_empty), 0);
        for (int g = 0; g < 8; g++) begin
            repeat (8) pull(0);
            close_run();
            if (g == 0) check("qovf_grp0", 32'(tx_bdi), 32'h49);
            if (g == 7) check("qovf_grp7", 32'(tx_bdi), 32'h92);
        end
        check("qovf_drained", 32'(resp_bdi_empty), 1);

        // mixed traffic, checked cycle by cycle against the model
        for (int c = 0; c < 300; c++) begin
            afu_tlx_rdata_valid = 1'($urandom_range(0, 1));
            afu_tlx_rdata_bdi   = 1'($urandom_range(0, 1));
            afu_tlx_cdata_valid = 1'($urandom_range(0, 1));
            afu_tlx_cdata_bdi   = 1'($urandom_range(0, 1));
            data_pull_v         = 1'($urandom_range(0, 1));
            data_pull_vc        = 1'($urandom_range(0, 1));
            ctl_flit_send       = ($urandom_range(0, 5) == 0);
            step();
        end

        // reset mid-run discards everything and issues no strobe
        push_r(1); push_r(1); pull(0); pull(0);
        reset_n = 0;
        step();
        check("midrst_valid", 32'(tx_bdi_valid), 0);
        check("midrst_err",   32'(bdi_err), 0);
        check("midrst_empty", 32'({resp_bdi_empty, cmd_bdi_empty}), 32'b11);
        reset_n = 1;
        step();
        close_run();
        check("midrst_run_len", 32'(tx_run_length), 0);

`ifdef OCX_TLX_TX_BDI_INJECT_EN
        cfg_bdi_inject = 1;
        repeat (4) push_r(0);
        repeat (4) pull(0);
        close_run();
        check("inject_bdi", 32'(tx_bdi), 32'h0F);
        check("inject_len", 32'(tx_run_length), 4);
        cfg_bdi_inject = 0;
        step();
`endif

        step();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
